// File: rtl/fifo_wr_arb_rr_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    // Port ownership state: waiting to arbitrate, or one producer owns the port.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // Widest one-hot vector the helper can build; callers cast down to their width.
    localparam int unsigned ONEHOT_MAX = 64;

    // One-hot vector with bit idx set.
    function automatic logic [ONEHOT_MAX-1:0] onehot_from_idx(input int unsigned idx);
        return {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface fifo_wr_arb_rr_if #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(REQ_NUM)
);
    logic [REQ_NUM-1:0]            i_req;
    logic [REQ_NUM*DATA_WIDTH-1:0] i_data;
    logic [REQ_NUM-1:0]            i_last;
    logic [REQ_NUM-1:0]            o_gnt;
    logic                          o_fifo_wr_en;
    logic [DATA_WIDTH-1:0]         o_fifo_wr_data;
    logic                          i_fifo_full;
    logic                          o_busy;
    logic [ID_WIDTH-1:0]           o_owner;

    modport slave (
        input  i_req, i_data, i_last, i_fifo_full,
        output o_gnt, o_fifo_wr_en, o_fifo_wr_data, o_busy, o_owner
    );

    modport master (
        output i_req, i_data, i_last, i_fifo_full,
        input  o_gnt, o_fifo_wr_en, o_fifo_wr_data, o_busy, o_owner
    );
endinterface

// File: rtl/fifo_wr_arb_rr_sel.sv
// Round-robin winner select: first requester after the last-served pointer.
// The request vector is doubled so the search ptr+1 .. ptr+REQ_NUM never has
// to wrap; a mask keeps only that window and a plain priority encode finishes it.
module arb_rr_sel #(
    parameter int REQ_NUM  = 4,
    parameter int ID_WIDTH = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] winner,
    output logic                valid
);

    logic [2*REQ_NUM-1:0] req_dbl;
    logic [2*REQ_NUM-1:0] win_mask;
    logic [2*REQ_NUM-1:0] masked;

    // Keep only the REQ_NUM positions that follow the pointer.
    always_comb begin
        req_dbl  = {req, req};
        win_mask = '0;
        for (int i = 0; i < 2*REQ_NUM; i++) begin
            win_mask[i] = (i > int'(ptr)) && (i <= int'(ptr) + REQ_NUM);
        end
        masked = req_dbl & win_mask;
    end

    // Lowest set bit of the masked window wins; fold its position back into range.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 2*REQ_NUM-1; i >= 0; i--) begin
            if (masked[i]) begin
                winner = ID_WIDTH'(i % REQ_NUM);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb_rr.sv
// Round-robin arbiter sharing one FIFO write port between REQ_NUM producers.
// One idle cycle arbitrates, then the owner streams up to BURST_LEN beats or
// until its i_last; a full FIFO stalls the owner in place without a timeout.
module fifo_wr_arb_rr
    import fifo_arb_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = $clog2(REQ_NUM),
    parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fifo_wr_arb_rr_if.slave bus
);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [ID_WIDTH-1:0]   ptr_q,   ptr_d;

    logic [ID_WIDTH-1:0]   sel_winner;
    logic                  sel_valid;
    logic                  req_own;
    logic                  last_own;
    logic                  burst_end;
    logic                  beat;
    logic [REQ_NUM-1:0]    gnt;
    logic [DATA_WIDTH-1:0] wr_data;

    arb_rr_sel #(
        .REQ_NUM  (REQ_NUM),
        .ID_WIDTH (ID_WIDTH)
    ) u_sel (
        .req    (bus.i_req),
        .ptr    (ptr_q),
        .winner (sel_winner),
        .valid  (sel_valid)
    );

    // Owner's request/last and whether a beat moves this cycle.
    always_comb begin
        req_own   = bus.i_req[owner_q];
        last_own  = bus.i_last[owner_q];
        burst_end = (cnt_q == CNT_WIDTH'(BURST_LEN - 1));
        beat      = (state_q == ARB_OWN) && req_own && !bus.i_fifo_full;
    end

    // Grant strobe and write data mux; data is forced to zero when nothing moves.
    always_comb begin
        gnt     = beat ? REQ_NUM'(onehot_from_idx(int'(owner_q))) : '0;
        wr_data = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (beat && (owner_q == ID_WIDTH'(k))) begin
                wr_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: arbitrate in IDLE, count beats and decide burst exit in OWN.
    always_comb begin
        // NOTE: every _d takes its current value first, so no branch leaves one unassigned and no latch is inferred.
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    owner_d = sel_winner;
                    cnt_d   = '0;
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (!req_own) begin
                    // Producer let go (possibly before its first beat): it forfeits the turn.
                    state_d = ARB_IDLE;
                    ptr_d   = owner_q;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (last_own || burst_end) begin
                        state_d = ARB_IDLE;
                        ptr_d   = owner_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, owner, beat count and last-served pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= ID_WIDTH'(REQ_NUM - 1);
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_gnt          = gnt;
    assign bus.o_fifo_wr_en   = beat;
    assign bus.o_fifo_wr_data = wr_data;
    assign bus.o_busy         = (state_q == ARB_OWN);
    assign bus.o_owner        = owner_q;

endmodule

// File: tb/tb_fifo_wr_arb_rr.sv
// Directed bench for the round-robin FIFO write-port arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fifo_wr_arb_rr;

    localparam int REQ_NUM = 4;
    localparam int DW      = 32;
    localparam int BL      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arb_rr_if #(.REQ_NUM(REQ_NUM), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arb_rr #(
        .REQ_NUM    (REQ_NUM),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] fifo_q[$];

    // FIFO model: capture every word written on a rising edge.
    always @(posedge clk) begin
        if (rst_n && bus.o_fifo_wr_en) fifo_q.push_back(bus.o_fifo_wr_data);
    end

    function automatic logic [31:0] pdata(input int k, input int n);
        return {4'hA, 4'(k), 24'(n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int n);
        for (int k = 0; k < REQ_NUM; k++) bus.i_data[k*DW +: DW] = pdata(k, n);
    endtask

    // Check one cycle's outputs at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic exp_busy, input int exp_owner,
                       input logic [3:0] exp_gnt, input logic [31:0] exp_data);
        @(negedge clk);
        check({tag, " busy"}, 32'(bus.o_busy), 32'(exp_busy));
        if (exp_busy) check({tag, " owner"}, 32'(bus.o_owner), 32'(exp_owner));
        check({tag, " gnt"}, 32'(bus.o_gnt), 32'(exp_gnt));
        check({tag, " wr_en"}, 32'(bus.o_fifo_wr_en), 32'(|exp_gnt));
        check({tag, " wr_data"}, bus.o_fifo_wr_data, exp_data);
        @(posedge clk);
        #1;
    endtask

    task automatic check_fifo(input string tag, input int k, input int n_exp);
        logic [31:0] got;
        check({tag, " size"}, 32'(fifo_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            got = (i < fifo_q.size()) ? fifo_q[i] : 32'hDEAD_DEAD;
            check($sformatf("%s word%0d", tag, i), got, pdata(k, i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, " owner"}, 32'(bus.o_owner), 32'd0);
        check({tag, " gnt"}, 32'(bus.o_gnt), 32'd0);
        check({tag, " wr_en"}, 32'(bus.o_fifo_wr_en), 32'd0);
        check({tag, " wr_data"}, bus.o_fifo_wr_data, 32'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] oh;
        bus.i_req       = '0;
        bus.i_last      = '0;
        bus.i_fifo_full = 1'b0;
        set_data(0);

        // Reset values.
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, 6-beat packet split 4 + 2 with one idle cycle between.
        fifo_q.delete();
        bus.i_req = 4'b0010;
        cyc("s1 arb", 1'b0, 0, 4'b0000, 32'd0);
        for (int n = 0; n < 4; n++) begin
            set_data(n);
            cyc($sformatf("s1 b%0d", n), 1'b1, 1, 4'b0010, pdata(1, n));
        end
        cyc("s1 gap", 1'b0, 0, 4'b0000, 32'd0);
        for (int n = 4; n < 6; n++) begin
            set_data(n);
            bus.i_last = (n == 5) ? 4'b0010 : 4'b0000;
            cyc($sformatf("s1 b%0d", n), 1'b1, 1, 4'b0010, pdata(1, n));
        end
        bus.i_req  = '0;
        bus.i_last = '0;
        cyc("s1 idle", 1'b0, 0, 4'b0000, 32'd0);
        check_fifo("s1 fifo", 1, 6);

        // All four requesting: owners 0,1,2,3,0, four beats each, idle bubble between.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            oh = 4'(1 << (g % 4));
            cyc($sformatf("s2 gap%0d", g), 1'b0, 0, 4'b0000, 32'd0);
            for (int b = 0; b < 4; b++) begin
                set_data(g*4 + b);
                cyc($sformatf("s2 g%0d b%0d", g, b), 1'b1, g % 4, oh, pdata(g % 4, g*4 + b));
            end
        end
        bus.i_req = '0;
        cyc("s2 idle", 1'b0, 0, 4'b0000, 32'd0);

        // Full stall: owner 2 stalls 3 cycles after its first beat, then finishes 4 beats.
        fifo_q.delete();
        bus.i_req = 4'b0100;
        set_data(0);
        cyc("s3 arb", 1'b0, 0, 4'b0000, 32'd0);
        cyc("s3 b0", 1'b1, 2, 4'b0100, pdata(2, 0));
        set_data(1);
        bus.i_fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) cyc($sformatf("s3 stall%0d", s), 1'b1, 2, 4'b0000, 32'd0);
        bus.i_fifo_full = 1'b0;
        for (int n = 1; n < 4; n++) begin
            set_data(n);
            cyc($sformatf("s3 b%0d", n), 1'b1, 2, 4'b0100, pdata(2, n));
        end
        bus.i_req = '0;
        cyc("s3 idle", 1'b0, 0, 4'b0000, 32'd0);
        check_fifo("s3 fifo", 2, 4);

        // Early release: owner 0 drops after 2 beats, producer 3 is next.
        bus.i_req = 4'b0001;
        set_data(0);
        cyc("s4 arb", 1'b0, 0, 4'b0000, 32'd0);
        bus.i_req = 4'b1001;
        cyc("s4 b0", 1'b1, 0, 4'b0001, pdata(0, 0));
        set_data(1);
        cyc("s4 b1", 1'b1, 0, 4'b0001, pdata(0, 1));
        bus.i_req = 4'b1000;
        cyc("s4 release", 1'b1, 0, 4'b0000, 32'd0);
        cyc("s4 arb2", 1'b0, 0, 4'b0000, 32'd0);
        bus.i_last = 4'b1000;
        set_data(2);
        cyc("s4 own3", 1'b1, 3, 4'b1000, pdata(3, 2));
        bus.i_req  = '0;
        bus.i_last = '0;
        cyc("s4 idle", 1'b0, 0, 4'b0000, 32'd0);

        // Pointer wrap: ptr=3 with requests 0 and 3, producer 0 must win.
        bus.i_req  = 4'b1001;
        bus.i_last = 4'b1001;
        set_data(7);
        cyc("s5 arb", 1'b0, 0, 4'b0000, 32'd0);
        cyc("s5 wrap", 1'b1, 0, 4'b0001, pdata(0, 7));
        bus.i_req  = '0;
        bus.i_last = '0;
        cyc("s5 idle", 1'b0, 0, 4'b0000, 32'd0);

        // Async reset mid-burst at count=2, then producer 0 wins first.
        bus.i_req = 4'b0010;
        set_data(0);
        cyc("s6 arb", 1'b0, 0, 4'b0000, 32'd0);
        cyc("s6 b0", 1'b1, 1, 4'b0010, pdata(1, 0));
        set_data(1);
        cyc("s6 b1", 1'b1, 1, 4'b0010, pdata(1, 1));
        set_data(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s6 rst");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.i_req = 4'b1111;
        cyc("s6 arb2", 1'b0, 0, 4'b0000, 32'd0);
        cyc("s6 first", 1'b1, 0, 4'b0001, pdata(0, 2));
        bus.i_req = '0;
        cyc("s6 release", 1'b1, 0, 4'b0000, 32'd0);
        cyc("s6 idle", 1'b0, 0, 4'b0000, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb_rr.md
Name: fifo_wr_arb_rr

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port between REQ_NUM producers.
- Grants ownership to one producer per burst, up to BURST_LEN beats or until that producer's i_last.
- Stalls on FIFO full, then rotates priority to the next requester.
- Sits directly in front of the FIFO write interface (wr_en / wr_data / full).

Parameters:
- REQ_NUM, 4, number of requesting producers (>=2).
- DATA_WIDTH, 32, data width per beat.
- BURST_LEN, 4, maximum beats per grant (>=1).
- ID_WIDTH, $clog2(REQ_NUM), width of owner index.
- CNT_WIDTH, $clog2(BURST_LEN+1), width of beat counter.

Ports:
- i_clk  input  1  single clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req  input  REQ_NUM  per-producer request/valid; bit k = producer k has a beat.
- i_data  input  REQ_NUM*DATA_WIDTH  producer k data at [k*DATA_WIDTH +: DATA_WIDTH].
- i_last  input  REQ_NUM  producer k marks final beat of its packet.
- o_gnt  output  REQ_NUM  one-hot beat-accept strobe to producer; beat consumed this cycle.
- o_fifo_wr_en  output  1  FIFO write enable.
- o_fifo_wr_data  output  DATA_WIDTH  FIFO write data.
- i_fifo_full  input  1  FIFO full flag.
- o_busy  output  1  high while a producer owns the port.
- o_owner  output  ID_WIDTH  index of current owner; valid when o_busy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- Reset values:
  - state=IDLE, beat count=0, last-served pointer=REQ_NUM-1 (so producer 0 wins first).
  - o_gnt=0, o_fifo_wr_en=0, o_fifo_wr_data=0, o_busy=0, o_owner=0.
- State machine (typedef in package): IDLE, OWN.
- IDLE:
  - If |i_req: pick the first set bit searching ptr+1, ptr+2, ... modulo REQ_NUM.
  - Register owner, clear count, go to OWN.
  - No transfer happens in IDLE, so arbitration costs exactly 1 cycle.
- OWN:
  - beat = i_req[owner] && !i_fifo_full.
  - On beat: o_fifo_wr_en=1, o_gnt[owner]=1, o_fifo_wr_data=i_data[owner]; count+1.
  - o_gnt and o_fifo_wr_en are combinational from state/owner/i_req/i_fifo_full. o_fifo_wr_data is 0 when no beat.
  - Exit to IDLE, with ptr<=owner, in the same cycle as either:
    - beat && (i_last[owner] || count==BURST_LEN-1), or
    - !i_req[owner] (producer released early; no beat that cycle).
  - i_fifo_full with i_req[owner]=1: hold OWN, count unchanged, no gnt, no wr_en. No timeout.
- Non-owners never see o_gnt while OWN; their requests wait.
- Back-to-back bursts: each grant is followed by one IDLE cycle. Peak throughput is BURST_LEN/(BURST_LEN+1).
- Fairness: with all requesters continuously active, grants go 0,1,2,3,0,... Each requester is served within REQ_NUM grants.
- Requester drops i_req before first beat: exit as early release; ptr still advances to it (it forfeits its turn).
- Reset asserted mid-burst: immediate return to reset values. The partial packet is truncated; producers must restart.
- o_busy = (state==OWN). o_owner holds its last value in IDLE.

Decomposition:
- Package fifo_arb_pkg:
  - state enum (ARB_IDLE, ARB_OWN).
  - helper function for one-hot from index.
- Sub-module arb_rr_sel, purely combinational:
  - Inputs: req vector, last-served pointer.
  - Outputs: winner index and any-valid.
  - Implementation: double-width masked priority encode.
- Top module holds FSM, pointer, counter and data mux.

Test Plan:
- Single requester: i_req=4'b0010, 6 beats, i_last on beat 6, BURST_LEN=4, no full.
  - Required: 1 IDLE cycle, then gnt[1] x4, 1 IDLE cycle, then gnt[1] x2.
  - FIFO receives all 6 words in order.
- All four requesting continuously, i_last never asserted.
  - Required: owner sequence 0,1,2,3,0; each grant exactly 4 beats; one IDLE bubble between grants.
- Full stall: owner 2 mid-burst at count=1; i_fifo_full=1 for 3 cycles.
  - Required: no wr_en and no gnt during the stall; o_busy=1; resumes at count=1; total 4 beats.
- Early release: owner 0 drops i_req after 2 beats while i_req[3]=1.
  - Required: next cycle IDLE, then owner 3 (ptr=0, search 1,2,3).
- Pointer wrap: ptr=3, i_req=4'b1001.
  - Required: owner 0 chosen, not 3.
- Async reset pulse during OWN at count=2.
  - Required: all outputs 0 immediately; after release, i_req=4'b1111 grants owner 0 first.
